load_store_unit: RTL and testbench

Memory-access stage of the PLP core: takes the effective address formed from the sign/zero-extended immediate plus base register, performs LW/SW/LBU/SB over a single-outstanding request/ack data bus, and stalls the pipeline until the access completes. It sits between execute (address, store data, op) and writeback (load result). It handles big-endian byte-lane selection for LBU/SB using address bits [1:0], and reports misalignment and bus timeouts.

---
 rtl/plp_mem_pkg.sv | 34 +++
 rtl/lsu_lanes.sv | 57 +++++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/plp_mem_pkg.sv
// ============================================================================
// Module  : plp_mem_pkg
// Purpose : Shared memory-stage definitions: op encodings, LSU state enum
//           and small op-decoding helpers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package plp_mem_pkg;

   localparam logic [1:0] OP_LW  = 2'b00;
   localparam logic [1:0] OP_SW  = 2'b01;
   localparam logic [1:0] OP_LBU = 2'b10;
   localparam logic [1:0] OP_SB  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_DONE = 2'b10
   } lsu_state_t;

   // Word ops have op[1]==0 in this encoding
   function automatic logic is_word_op(input logic [1:0] op);
      return ~op[1];
   endfunction

   // Store ops have op[0]==1 in this encoding
   function automatic logic is_store_op(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lanes.sv
// ============================================================================
// Module  : lsu_lanes
// Purpose : Big-endian byte-lane steering for the load/store unit. Produces
//           byte enables and replicated store data for the outgoing request
//           and aligns returning read data into the load result.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_lanes
   import plp_mem_pkg::*;
(
   input  logic [1:0]  i_op,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_st_data,
   input  logic [31:0] i_ld_raw,
   output logic [3:0]  o_be,
   output logic [31:0] o_st_lanes,
   output logic [31:0] o_ld_result
);

   // Offset k selects bits [31-8k:24-8k]; shifting right by 8*(3-k) brings
   // that byte to the bottom. 3-k is simply ~k for a 2-bit offset.
   logic [4:0]  w_shift;
   logic [31:0] w_shifted;

   assign w_shift   = {~i_offset, 3'b000};
   assign w_shifted = i_ld_raw >> w_shift;

   // Lane selection per access type
   always_comb begin
      o_be        = 4'b0000;
      o_st_lanes  = 32'h0;
      o_ld_result = 32'h0;
      case (i_op)
         OP_LW: begin
            o_be        = 4'b1111;
            o_ld_result = i_ld_raw;
         end
         OP_SW: begin
            o_be        = 4'b1111;
            o_st_lanes  = i_st_data;
         end
         OP_LBU: begin
            o_be        = 4'b1000 >> i_offset;
            o_ld_result = {24'h0, w_shifted[7:0]};
         end
         default: begin
            o_be        = 4'b1000 >> i_offset;
            o_st_lanes  = {4{i_st_data[7:0]}};
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module  : load_store_unit
// Purpose : PLP memory-access stage. Runs LW/SW/LBU/SB over a single-
//           outstanding req/ack bus, stalls the pipeline until completion and
//           flags misaligned word accesses and bus timeouts.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit
   import plp_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [1:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   // Counter value seen during the last permitted BUS cycle
   localparam logic [15:0] C_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   lsu_state_t  r_state;
   lsu_state_t  w_next;
   logic [1:0]  r_op;
   logic [1:0]  r_off;
   logic [15:0] r_cnt;

   logic        w_misalign;
   logic        w_timeout;
   logic [1:0]  w_lane_op;
   logic [1:0]  w_lane_off;
   logic [3:0]  w_be;
   logic [31:0] w_st_lanes;
   logic [31:0] w_ld_result;

   assign w_misalign = is_word_op(op) & (addr[1:0] != 2'b00);
   assign w_timeout  = (r_cnt == C_CNT_LAST);

   // In IDLE the lanes steer the incoming request; afterwards they align
   // read data using the latched op and offset.
   assign w_lane_op  = (r_state == ST_IDLE) ? op        : r_op;
   assign w_lane_off = (r_state == ST_IDLE) ? addr[1:0] : r_off;

   lsu_lanes u_lanes (
      .i_op        (w_lane_op),
      .i_offset    (w_lane_off),
      .i_st_data   (wdata),
      .i_ld_raw    (bus_rdata),
      .o_be        (w_be),
      .o_st_lanes  (w_st_lanes),
      .o_ld_result (w_ld_result)
   );

   assign stall = ((r_state == ST_IDLE) & req_valid) | (r_state == ST_BUS);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; ack on the last permitted cycle beats the timeout
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) w_next = w_misalign ? ST_DONE : ST_BUS;
         end
         ST_BUS: begin
            if (bus_ack || w_timeout) w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Registered outputs, latched op/offset and the BUS-cycle counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op      <= OP_LW;
         r_off     <= 2'b00;
         r_cnt     <= 16'h0;
         done      <= 1'b0;
         rdata     <= 32'h0;
         bus_err   <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'h0;
         bus_be    <= 4'b0000;
         bus_wdata <= 32'h0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_op  <= op;
                  r_off <= addr[1:0];
                  r_cnt <= 16'h0;
                  if (w_misalign) begin
                     done    <= 1'b1;
                     bus_err <= 1'b1;
                     rdata   <= 32'h0;
                  end else begin
                     bus_req   <= 1'b1;
                     bus_we    <= is_store_op(op);
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_be    <= w_be;
                     bus_wdata <= w_st_lanes;
                  end
               end
            end
            ST_BUS: begin
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  done    <= 1'b1;
                  rdata   <= w_ld_result;
               end else if (w_timeout) begin
                  bus_req <= 1'b0;
                  done    <= 1'b1;
                  bus_err <= 1'b1;
                  rdata   <= 32'h0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
               done    <= 1'b0;
               bus_err <= 1'b0;
               rdata   <= 32'h0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module  : tb_load_store_unit
// Purpose : Directed self-checking bench for load_store_unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;
   import plp_mem_pkg::*;

   localparam int NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall, done, bus_err, bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_ack = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .op(op), .addr(addr),
      .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
      .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic        has_bus;
      logic        we;
      logic [31:0] baddr;
      logic [3:0]  be;
      logic [31:0] bwd;
      logic [31:0] exp_rdata;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   stallcnt, nbus, lat;
      logic got, seen_bus, s_we, s_err, s_req;
      logic [31:0] s_addr, s_wd, s_rd;
      logic [3:0]  s_be;
      stallcnt = 0; nbus = 0; lat = 0; got = 0; seen_bus = 0;
      s_we = 0; s_err = 0; s_req = 0; s_addr = 0; s_wd = 0; s_rd = 0; s_be = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
      bus_rdata = v.rdata; bus_ack = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d.accept_stall", idx), {31'h0, stall}, 32'h1);
      check($sformatf("v%0d.idle_done", idx), {31'h0, done}, 32'h0);
      if (stall) stallcnt++;
      for (int c = 1; c <= 20 && !got; c++) begin
         @(posedge clk); #1;
         req_valid = 1'b0;
         if (bus_req) begin
            nbus++;
            bus_ack = (nbus == v.delay + 1);
         end else begin
            bus_ack = 1'b0;
         end
         @(negedge clk);
         if (bus_req && !seen_bus) begin
            seen_bus = 1'b1;
            s_we = bus_we; s_addr = bus_addr; s_be = bus_be; s_wd = bus_wdata;
         end
         if (stall) stallcnt++;
         if (done) begin
            got = 1'b1; lat = c;
            s_rd = rdata; s_err = bus_err; s_req = bus_req;
         end
      end
      bus_ack = 1'b0;
      check($sformatf("v%0d.done_seen", idx), {31'h0, got}, 32'h1);
      check($sformatf("v%0d.latency", idx), lat, v.lat);
      check($sformatf("v%0d.stall_cycles", idx), stallcnt, v.lat);
      check($sformatf("v%0d.rdata", idx), s_rd, v.exp_rdata);
      check($sformatf("v%0d.bus_err", idx), {31'h0, s_err}, {31'h0, v.err});
      check($sformatf("v%0d.req_at_done", idx), {31'h0, s_req}, 32'h0);
      check($sformatf("v%0d.bus_cycle", idx), {31'h0, seen_bus}, {31'h0, v.has_bus});
      if (v.has_bus) begin
         check($sformatf("v%0d.bus_we", idx), {31'h0, s_we}, {31'h0, v.we});
         check($sformatf("v%0d.bus_addr", idx), s_addr, v.baddr);
         check($sformatf("v%0d.bus_be", idx), {28'h0, s_be}, {28'h0, v.be});
         check($sformatf("v%0d.bus_wdata", idx), s_wd, v.bwd);
      end
   endtask

   initial begin
      //          op      addr          wdata         rdata         dly    bus we baddr         be       bwd           exp_rdata     err lat
      vecs[0]  = '{OP_LW,  32'h0000_0100, 32'h0,        32'hDEADBEEF, 0,     1, 0, 32'h0000_0100, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 2};
      vecs[1]  = '{OP_LBU, 32'h0000_0103, 32'h0,        32'h11223344, 0,     1, 0, 32'h0000_0100, 4'b0001, 32'h0,        32'h00000044, 0, 2};
      vecs[2]  = '{OP_LBU, 32'h0000_0100, 32'h0,        32'h11223344, 0,     1, 0, 32'h0000_0100, 4'b1000, 32'h0,        32'h00000011, 0, 2};
      vecs[3]  = '{OP_LBU, 32'h0000_0102, 32'h0,        32'h11223344, 1,     1, 0, 32'h0000_0100, 4'b0010, 32'h0,        32'h00000033, 0, 3};
      vecs[4]  = '{OP_SB,  32'h0000_0201, 32'h000000AB, 32'h55555555, 0,     1, 1, 32'h0000_0200, 4'b0100, 32'hABABABAB, 32'h0,        0, 2};
      vecs[5]  = '{OP_SW,  32'h0000_0300, 32'hCAFEF00D, 32'hFFFFFFFF, 2,     1, 1, 32'h0000_0300, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 4};
      vecs[6]  = '{OP_SW,  32'h0000_0102, 32'h12345678, 32'h0,        0,     0, 0, 32'h0,         4'b0000, 32'h0,        32'h0,        1, 1};
      vecs[7]  = '{OP_LW,  32'h0000_0101, 32'h0,        32'hFFFFFFFF, 0,     0, 0, 32'h0,         4'b0000, 32'h0,        32'h0,        1, 1};
      vecs[8]  = '{OP_LW,  32'h0000_0400, 32'h0,        32'h12345678, 3,     1, 0, 32'h0000_0400, 4'b1111, 32'h0,        32'h12345678, 0, 5};
      vecs[9]  = '{OP_LW,  32'h0000_0500, 32'h0,        32'h87654321, NEVER, 1, 0, 32'h0000_0500, 4'b1111, 32'h0,        32'h0,        1, 5};
      vecs[10] = '{OP_SB,  32'h0000_0203, 32'h1234565A, 32'h0,        0,     1, 1, 32'h0000_0200, 4'b0001, 32'h5A5A5A5A, 32'h0,        0, 2};
      vecs[11] = '{OP_LBU, 32'h0000_0501, 32'h0,        32'hA1B2C3D4, NEVER, 1, 0, 32'h0000_0500, 4'b0100, 32'h0,        32'h0,        1, 5};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.stall", {31'h0, stall}, 32'h0);
      check("rst.done", {31'h0, done}, 32'h0);
      check("rst.rdata", rdata, 32'h0);
      check("rst.bus_err", {31'h0, bus_err}, 32'h0);
      check("rst.bus_req", {31'h0, bus_req}, 32'h0);
      check("rst.bus_we", {31'h0, bus_we}, 32'h0);
      check("rst.bus_addr", bus_addr, 32'h0);
      check("rst.bus_be", {28'h0, bus_be}, 32'h0);
      check("rst.bus_wdata", bus_wdata, 32'h0);
      #1 rst_n = 1'b1;

      // Ack while idle must be ignored
      @(posedge clk); #1 bus_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_ack.done", {31'h0, done}, 32'h0);
         check("idle_ack.bus_req", {31'h0, bus_req}, 32'h0);
      end
      bus_ack = 1'b0;

      // Table-driven vectors, issued back to back
      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // req_valid held high through DONE: DONE ignores it, IDLE re-accepts
      @(posedge clk); #1;
      req_valid = 1'b1; op = OP_SW; addr = 32'h0000_0102; wdata = 32'h0;
      @(negedge clk);
      check("hold.n_stall", {31'h0, stall}, 32'h1);
      @(negedge clk);
      check("hold.n1_done", {31'h0, done}, 32'h1);
      check("hold.n1_stall", {31'h0, stall}, 32'h0);
      @(negedge clk);
      check("hold.n2_done", {31'h0, done}, 32'h0);
      check("hold.n2_stall", {31'h0, stall}, 32'h1);
      @(negedge clk);
      check("hold.n3_done", {31'h0, done}, 32'h1);
      check("hold.n3_err", {31'h0, bus_err}, 32'h1);
      #1 req_valid = 1'b0;

      // Reset in the middle of a bus access
      @(posedge clk); #1;
      req_valid = 1'b1; op = OP_LW; addr = 32'h0000_0600;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      check("midrst.bus_req_before", {31'h0, bus_req}, 32'h1);
      check("midrst.stall_before", {31'h0, stall}, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst.bus_req", {31'h0, bus_req}, 32'h0);
      check("midrst.stall", {31'h0, stall}, 32'h0);
      check("midrst.bus_addr", bus_addr, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_vec(100, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
